// File: rtl/game_pkg.sv
// Shared play-field constants, sweep FSM states and the enemy entry layout.
// Also holds the inclusive box-overlap test used for player and enemy collisions.
package game_pkg;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;
  localparam int PLAYER_W_DEF = 3;

  typedef enum logic [1:0] {ST_WAIT, ST_UPD, ST_COLL, ST_DONE} state_t;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] w;
    logic [2:0] dx;
    logic [2:0] dy;
    logic       left;
    logic       up;
  } enemy_t;

  // A box covers [pos, pos+size-1] on each axis; touching pixels count as overlap.
  function automatic logic boxes_overlap(input logic [9:0] ax, input logic [9:0] ay,
                                         input logic [9:0] aw, input logic [9:0] bx,
                                         input logic [9:0] by, input logic [9:0] bw);
    return (ax < bx + bw) && (bx < ax + aw) && (ay < by + bw) && (by < ay + aw);
  endfunction

endpackage

// File: rtl/axis_step.sv
// One-axis bounce step: moves pos by delta toward 0 or toward limit, clamping and flipping at the walls.
// Purely combinational; far-edge arithmetic is one bit wider than the position.
module axis_step #(
  parameter int W = 8
) (
  input  logic [W-1:0] pos_i,
  input  logic [2:0]   delta_i,
  input  logic [2:0]   size_i,
  input  logic         dir_i,
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] pos_o,
  output logic         dir_o
);

  localparam int W1 = W + 1;

  logic [W:0]   far_edge;
  logic [W-1:0] delta_ext;
  logic [W-1:0] size_ext;

  always_comb begin
    delta_ext = W'(delta_i);
    size_ext  = W'(size_i);
    far_edge  = {1'b0, pos_i} + W1'(size_i) + W1'(delta_i);
    pos_o     = pos_i;
    dir_o     = dir_i;
    if (dir_i) begin
      // dir_i=1 means moving toward zero (left / up)
      if (pos_i <= delta_ext) begin
        pos_o = '0;
        dir_o = 1'b0;
      end else begin
        pos_o = pos_i - delta_ext;
      end
    end else if (far_edge > {1'b0, limit_i}) begin
      pos_o = limit_i - size_ext;
      dir_o = 1'b1;
    end else begin
      pos_o = pos_i + delta_ext;
    end
  end

endmodule

// File: rtl/enemy_array_ctrl.sv
// Enemy array: per tick, sweeps movement then player collision one enemy per cycle; move pulses 2*N_ENEMY+1 cycles after the tick.
// ENEMY_BOUNCE_EN adds pairwise enemy-enemy bounce during the collision sweep; no backpressure, play=0 only holds the tick counter.
module enemy_array_ctrl
  import game_pkg::*;
#(
  parameter int N_ENEMY  = 4,
  parameter int RATE_DIV = 1000000,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int PLAYER_W = PLAYER_W_DEF,
  localparam int IW = (N_ENEMY > 1) ? $clog2(N_ENEMY) : 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               play,
  input  logic               load_level,
  input  logic               cfg_we,
  input  logic [IW-1:0]      cfg_idx,
  input  logic [7:0]         cfg_x,
  input  logic [6:0]         cfg_y,
  input  logic [2:0]         cfg_w,
  input  logic [2:0]         cfg_dx,
  input  logic [2:0]         cfg_dy,
  input  logic               cfg_left,
  input  logic               cfg_up,
  input  logic [7:0]         player_x,
  input  logic [6:0]         player_y,
  input  logic               hit_clear,
  input  logic [IW-1:0]      rd_idx,
  output logic [7:0]         rd_x,
  output logic [6:0]         rd_y,
  output logic [2:0]         rd_w,
  output logic               move,
  output logic               player_hit,
  output logic [N_ENEMY-1:0] hit_mask
);

  localparam int CW = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(RATE_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_ENEMY - 1);

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      idx_q, idx_d;
  enemy_t             shadow_q [N_ENEMY];
  enemy_t             shadow_d [N_ENEMY];
  enemy_t             live_q   [N_ENEMY];
  enemy_t             live_d   [N_ENEMY];
  logic [N_ENEMY-1:0] hit_mask_q, hit_mask_d;
  logic               player_hit_q, player_hit_d;
  logic [7:0]         rd_x_q;
  logic [6:0]         rd_y_q;
  logic [2:0]         rd_w_q;

  enemy_t     cur;
  logic [7:0] nx;
  logic [6:0] ny;
  logic       nleft, nup;
  logic       cur_hits_player;

  assign cur = live_q[idx_q];

  axis_step #(.W(8)) u_step_x (
    .pos_i(cur.x), .delta_i(cur.dx), .size_i(cur.w), .dir_i(cur.left),
    .limit_i(8'(SCREEN_W)), .pos_o(nx), .dir_o(nleft)
  );

  axis_step #(.W(7)) u_step_y (
    .pos_i(cur.y), .delta_i(cur.dy), .size_i(cur.w), .dir_i(cur.up),
    .limit_i(7'(SCREEN_H)), .pos_o(ny), .dir_o(nup)
  );

  assign cur_hits_player = (cur.w != 3'd0) &&
    boxes_overlap({2'b0, cur.x}, {3'b0, cur.y}, {7'b0, cur.w},
                  {2'b0, player_x}, {3'b0, player_y}, 10'(PLAYER_W));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    live_d       = live_q;
    hit_mask_d   = hit_mask_q;
    player_hit_d = player_hit_q;

    if (cfg_we && !play && (int'(cfg_idx) < N_ENEMY)) begin
      shadow_d[cfg_idx] = '{x: cfg_x, y: cfg_y, w: cfg_w, dx: cfg_dx,
                            dy: cfg_dy, left: cfg_left, up: cfg_up};
    end

    // Clear first so a hit found this same cycle survives
    if (hit_clear) begin
      hit_mask_d   = '0;
      player_hit_d = 1'b0;
    end

    case (state_q)
      ST_WAIT: begin
        if (play) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = ST_UPD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_UPD: begin
        if (cur.w != 3'd0) begin
          live_d[idx_q].x    = nx;
          live_d[idx_q].y    = ny;
          live_d[idx_q].left = nleft;
          live_d[idx_q].up   = nup;
        end
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          state_d = ST_COLL;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_COLL: begin
        if (cur_hits_player) begin
          hit_mask_d[idx_q] = 1'b1;
          player_hit_d      = 1'b1;
        end
`ifdef ENEMY_BOUNCE_EN
        for (int j = 0; j < N_ENEMY; j++) begin
          if (j > int'(idx_q) && cur.w != 3'd0 && live_q[j].w != 3'd0 &&
              boxes_overlap({2'b0, cur.x}, {3'b0, cur.y}, {7'b0, cur.w},
                            {2'b0, live_q[j].x}, {3'b0, live_q[j].y}, {7'b0, live_q[j].w})) begin
            live_d[j].left     = ~live_d[j].left;
            live_d[j].up       = ~live_d[j].up;
            live_d[idx_q].left = ~live_d[idx_q].left;
            live_d[idx_q].up   = ~live_d[idx_q].up;
          end
        end
`endif
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_WAIT;
      default: state_d = ST_WAIT;
    endcase

    // Level load aborts any sweep in flight
    if (load_level) begin
      live_d       = shadow_q;
      cnt_d        = '0;
      idx_d        = '0;
      hit_mask_d   = '0;
      player_hit_d = 1'b0;
      state_d      = ST_WAIT;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_WAIT;
      cnt_q        <= '0;
      idx_q        <= '0;
      hit_mask_q   <= '0;
      player_hit_q <= 1'b0;
      rd_x_q       <= '0;
      rd_y_q       <= '0;
      rd_w_q       <= '0;
      for (int i = 0; i < N_ENEMY; i++) begin
        shadow_q[i] <= '0;
        live_q[i]   <= '0;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      hit_mask_q   <= hit_mask_d;
      player_hit_q <= player_hit_d;
      shadow_q     <= shadow_d;
      live_q       <= live_d;
      if (int'(rd_idx) < N_ENEMY) begin
        rd_x_q <= live_q[rd_idx].x;
        rd_y_q <= live_q[rd_idx].y;
        rd_w_q <= live_q[rd_idx].w;
      end else begin
        rd_x_q <= '0;
        rd_y_q <= '0;
        rd_w_q <= '0;
      end
    end
  end

  assign rd_x       = rd_x_q;
  assign rd_y       = rd_y_q;
  assign rd_w       = rd_w_q;
  assign move       = (state_q == ST_DONE);
  assign player_hit = player_hit_q;
  assign hit_mask   = hit_mask_q;

endmodule

// File: tb/tb_enemy_array_ctrl.sv
// Scenario bench for enemy_array_ctrl at RATE_DIV=4, N_ENEMY=4; expected entry values queued per move pulse.
`timescale 1ns/1ps
module tb_enemy_array_ctrl;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       play = 1'b0;
  logic       load_level = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_idx = '0;
  logic [7:0] cfg_x = '0;
  logic [6:0] cfg_y = '0;
  logic [2:0] cfg_w = '0;
  logic [2:0] cfg_dx = '0;
  logic [2:0] cfg_dy = '0;
  logic       cfg_left = 1'b0;
  logic       cfg_up = 1'b0;
  logic [7:0] player_x = '0;
  logic [6:0] player_y = '0;
  logic       hit_clear = 1'b0;
  logic [1:0] rd_idx = '0;
  logic [7:0] rd_x;
  logic [6:0] rd_y;
  logic [2:0] rd_w;
  logic       move;
  logic       player_hit;
  logic [3:0] hit_mask;

  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [3:0] mask;
    logic       hit;
  } exp_t;
  exp_t exp_q[$];

  enemy_array_ctrl #(.N_ENEMY(4), .RATE_DIV(4)) dut (
    .clk(clk), .resetn(resetn), .play(play), .load_level(load_level),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_w(cfg_w),
    .cfg_dx(cfg_dx), .cfg_dy(cfg_dy), .cfg_left(cfg_left), .cfg_up(cfg_up),
    .player_x(player_x), .player_y(player_y), .hit_clear(hit_clear),
    .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y), .rd_w(rd_w),
    .move(move), .player_hit(player_hit), .hit_mask(hit_mask)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0; play = 1'b0; load_level = 1'b0; cfg_we = 1'b0; hit_clear = 1'b0;
    tick(); tick();
    resetn = 1'b1;
  endtask

  task automatic cfg_write(input int idx, input int x, input int y, input int w,
                           input int dx, input int dy, input logic left, input logic up);
    cfg_idx = 2'(idx); cfg_x = 8'(x); cfg_y = 7'(y); cfg_w = 3'(w);
    cfg_dx = 3'(dx); cfg_dy = 3'(dy); cfg_left = left; cfg_up = up; cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic do_load();
    load_level = 1'b1;
    tick();
    load_level = 1'b0;
  endtask

  // Returns the tick count at which move is seen, or -1 if the budget runs out
  task automatic wait_move(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (move === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    rd_idx = 2'd2;
    tick();
    n_checks++; if (rd_x !== 8'd0) $display("FAIL reset_rd_x: got %0d want 0", rd_x); else n_pass++;
    n_checks++; if (rd_y !== 7'd0) $display("FAIL reset_rd_y: got %0d want 0", rd_y); else n_pass++;
    n_checks++; if (rd_w !== 3'd0) $display("FAIL reset_rd_w: got %0d want 0", rd_w); else n_pass++;
    n_checks++; if (move !== 1'b0) $display("FAIL reset_move: got %b want 0", move); else n_pass++;
    n_checks++; if (player_hit !== 1'b0) $display("FAIL reset_player_hit: got %b want 0", player_hit); else n_pass++;
    n_checks++; if (hit_mask !== 4'b0) $display("FAIL reset_hit_mask: got %b want 0000", hit_mask); else n_pass++;
  endtask

  task automatic test_move();
    int n1, n2;
    exp_t e;
    do_reset();
    player_x = 8'd0; player_y = 7'd0;
    cfg_write(0, 10, 50, 1, 2, 0, 1'b0, 1'b0);
    cfg_write(2, 30, 60, 0, 2, 2, 1'b0, 1'b0);
    do_load();
    rd_idx = 2'd0;
    tick();
    n_checks++; if (rd_x !== 8'd10) $display("FAIL load_rd_x: got %0d want 10", rd_x); else n_pass++;
    exp_q.push_back('{x: 8'd12, y: 7'd50, mask: 4'b0, hit: 1'b0});
    exp_q.push_back('{x: 8'd14, y: 7'd50, mask: 4'b0, hit: 1'b0});
    play = 1'b1;
    wait_move(40, n1);
    n_checks++; if (n1 !== 12) $display("FAIL first_move_latency: got %0d want 12", n1); else n_pass++;
    e = exp_q.pop_front();
    n_checks++; if (rd_x !== e.x) $display("FAIL move1_x: got %0d want %0d", rd_x, e.x); else n_pass++;
    n_checks++; if (rd_y !== e.y) $display("FAIL move1_y: got %0d want %0d", rd_y, e.y); else n_pass++;
    tick();
    n_checks++; if (move !== 1'b0) $display("FAIL move_width: got %b want 0", move); else n_pass++;
    wait_move(40, n2);
    n_checks++; if (n2 + 1 !== 13) $display("FAIL move_period: got %0d want 13", n2 + 1); else n_pass++;
    e = exp_q.pop_front();
    n_checks++; if (rd_x !== e.x) $display("FAIL move2_x: got %0d want %0d", rd_x, e.x); else n_pass++;
    n_checks++; if (rd_y !== e.y) $display("FAIL move2_y: got %0d want %0d", rd_y, e.y); else n_pass++;
    play = 1'b0;
    rd_idx = 2'd2;
    tick();
    n_checks++; if (rd_x !== 8'd30) $display("FAIL inactive_x: got %0d want 30", rd_x); else n_pass++;
    n_checks++; if (rd_w !== 3'd0) $display("FAIL inactive_w: got %0d want 0", rd_w); else n_pass++;
  endtask

  task automatic test_right_wall();
    int n;
    exp_t e;
    do_reset();
    cfg_write(0, 156, 50, 3, 2, 0, 1'b0, 1'b0);
    do_load();
    rd_idx = 2'd0;
    exp_q.push_back('{x: 8'd157, y: 7'd50, mask: 4'b0, hit: 1'b0});
    exp_q.push_back('{x: 8'd155, y: 7'd50, mask: 4'b0, hit: 1'b0});
    play = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wait_move(40, n);
      e = exp_q.pop_front();
      n_checks++; if (n < 0 || rd_x !== e.x) $display("FAIL right_wall_x%0d: got %0d want %0d (wait %0d)", k, rd_x, e.x, n); else n_pass++;
    end
    play = 1'b0;
  endtask

  task automatic test_left_wall();
    int n;
    exp_t e;
    do_reset();
    cfg_write(0, 1, 50, 1, 2, 0, 1'b1, 1'b0);
    do_load();
    rd_idx = 2'd0;
    exp_q.push_back('{x: 8'd0, y: 7'd50, mask: 4'b0, hit: 1'b0});
    exp_q.push_back('{x: 8'd2, y: 7'd50, mask: 4'b0, hit: 1'b0});
    play = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wait_move(40, n);
      e = exp_q.pop_front();
      n_checks++; if (n < 0 || rd_x !== e.x) $display("FAIL left_wall_x%0d: got %0d want %0d (wait %0d)", k, rd_x, e.x, n); else n_pass++;
    end
    play = 1'b0;
  endtask

  task automatic test_hit();
    int n;
    exp_t e;
    do_reset();
    player_x = 8'd80; player_y = 7'd115;
    cfg_write(0, 10, 50, 1, 2, 0, 1'b0, 1'b0);
    cfg_write(1, 81, 116, 2, 0, 0, 1'b0, 1'b0);
    do_load();
    n_checks++; if (player_hit !== 1'b0) $display("FAIL hit_before: got %b want 0", player_hit); else n_pass++;
    exp_q.push_back('{x: 8'd0, y: 7'd0, mask: 4'b0010, hit: 1'b1});
    play = 1'b1;
    wait_move(40, n);
    play = 1'b0;
    e = exp_q.pop_front();
    n_checks++; if (n < 0 || hit_mask !== e.mask) $display("FAIL hit_mask: got %b want %b (wait %0d)", hit_mask, e.mask, n); else n_pass++;
    n_checks++; if (player_hit !== e.hit) $display("FAIL player_hit: got %b want %b", player_hit, e.hit); else n_pass++;
    tick();
    hit_clear = 1'b1;
    tick();
    hit_clear = 1'b0;
    n_checks++; if (hit_mask !== 4'b0) $display("FAIL hit_clear_mask: got %b want 0000", hit_mask); else n_pass++;
    n_checks++; if (player_hit !== 1'b0) $display("FAIL hit_clear_flag: got %b want 0", player_hit); else n_pass++;
  endtask

  task automatic test_cfg_lock_and_load();
    int n;
    do_reset();
    player_x = 8'd0; player_y = 7'd0;
    cfg_write(0, 20, 50, 1, 2, 0, 1'b0, 1'b0);
    do_load();
    rd_idx = 2'd0;
    // Write attempt lands on the first counting cycle and must be dropped
    play = 1'b1;
    cfg_idx = 2'd0; cfg_x = 8'd99; cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
    tick(); tick(); tick();
    tick();
    load_level = 1'b1;
    tick();
    load_level = 1'b0;
    play = 1'b0;
    wait_move(15, n);
    n_checks++; if (n !== -1) $display("FAIL load_abort_move: got pulse at %0d want none", n); else n_pass++;
    n_checks++; if (rd_x !== 8'd20) $display("FAIL load_restore_x: got %0d want 20", rd_x); else n_pass++;
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    do_reset();
    player_x = 8'd80; player_y = 7'd115;
    cfg_write(0, 10, 50, 1, 2, 0, 1'b0, 1'b0);
    cfg_write(1, 81, 116, 2, 0, 0, 1'b0, 1'b0);
    do_load();
    rd_idx = 2'd1;
    play = 1'b1;
    wait_move(40, n);
    for (int k = 0; k < 6; k++) tick();
    n_checks++; if (n < 0 || player_hit !== 1'b1) $display("FAIL pre_reset_hit: got %b want 1 (wait %0d)", player_hit, n); else n_pass++;
    resetn = 1'b0;
    tick();
    n_checks++; if (rd_x !== 8'd0) $display("FAIL midreset_rd_x: got %0d want 0", rd_x); else n_pass++;
    n_checks++; if (rd_y !== 7'd0) $display("FAIL midreset_rd_y: got %0d want 0", rd_y); else n_pass++;
    n_checks++; if (rd_w !== 3'd0) $display("FAIL midreset_rd_w: got %0d want 0", rd_w); else n_pass++;
    n_checks++; if (move !== 1'b0) $display("FAIL midreset_move: got %b want 0", move); else n_pass++;
    n_checks++; if (player_hit !== 1'b0) $display("FAIL midreset_hit: got %b want 0", player_hit); else n_pass++;
    n_checks++; if (hit_mask !== 4'b0) $display("FAIL midreset_mask: got %b want 0000", hit_mask); else n_pass++;
    resetn = 1'b1;
    play = 1'b0;
    wait_move(15, n);
    n_checks++; if (n !== -1) $display("FAIL midreset_no_move: got pulse at %0d want none", n); else n_pass++;
  endtask

`ifdef ENEMY_BOUNCE_EN
  task automatic test_bounce();
    int n;
    exp_t e0, e1;
    do_reset();
    player_x = 8'd0; player_y = 7'd0;
    cfg_write(0, 50, 50, 4, 1, 0, 1'b0, 1'b0);
    cfg_write(1, 52, 50, 4, 1, 0, 1'b1, 1'b0);
    do_load();
    exp_q.push_back('{x: 8'd51, y: 7'd50, mask: 4'b0, hit: 1'b0});
    exp_q.push_back('{x: 8'd51, y: 7'd50, mask: 4'b0, hit: 1'b0});
    exp_q.push_back('{x: 8'd50, y: 7'd50, mask: 4'b0, hit: 1'b0});
    exp_q.push_back('{x: 8'd52, y: 7'd50, mask: 4'b0, hit: 1'b0});
    for (int k = 0; k < 2; k++) begin
      play = 1'b1;
      wait_move(40, n);
      play = 1'b0;
      e0 = exp_q.pop_front();
      e1 = exp_q.pop_front();
      rd_idx = 2'd0;
      tick();
      n_checks++; if (n < 0 || rd_x !== e0.x) $display("FAIL bounce_e0_x%0d: got %0d want %0d", k, rd_x, e0.x); else n_pass++;
      rd_idx = 2'd1;
      tick();
      n_checks++; if (rd_x !== e1.x) $display("FAIL bounce_e1_x%0d: got %0d want %0d", k, rd_x, e1.x); else n_pass++;
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_move();
    test_right_wall();
    test_left_wall();
    test_hit();
    test_cfg_lock_and_load();
    test_reset_mid_sweep();
`ifdef ENEMY_BOUNCE_EN
    test_bounce();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
